// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB round-robin arbiter.
// Holds the FSM state encoding, the pointer-advance rule and the one-hot decoder.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    // Widest requester vector the one-hot decoder accepts.
    localparam int unsigned MAX_MST = 32;

    // Next round-robin start index; explicit wrap keeps non-power-of-2 counts correct.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    function automatic int unsigned onehot_to_bin(input logic [MAX_MST-1:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int unsigned i = 0; i < MAX_MST; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
// Produces a one-hot grant plus a valid flag when any request is present.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int N_MST = 2
) (
    input  logic [N_MST-1:0]         req,
    input  logic [$clog2(N_MST)-1:0] ptr,
    output logic [N_MST-1:0]         gnt_oh,
    output logic                     gnt_valid
);

    int unsigned slot_s;
    logic        found_s;

    // Walk the slots in priority order starting at ptr and take the first request.
    always_comb begin
        gnt_oh  = '0;
        found_s = 1'b0;
        slot_s  = 32'd0;
        for (int unsigned k = 0; k < N_MST; k++) begin
            slot_s = 32'(ptr) + k;
            if (slot_s >= N_MST) begin
                slot_s = slot_s - N_MST;
            end else begin
                slot_s = slot_s;
            end
            for (int unsigned i = 0; i < N_MST; i++) begin
                if (!found_s && req[i] && (i == slot_s)) begin
                    gnt_oh[i] = 1'b1;
                    found_s   = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
        gnt_valid = found_s;
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB port among N_MST requesters.
// Regenerates SETUP/ACCESS, routes completion to the granted requester, optional watchdog.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_MST          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_MST*ADDR_WIDTH-1:0]   slv_paddr_i,
    input  logic [N_MST-1:0]              slv_psel_i,
    input  logic [N_MST-1:0]              slv_penable_i,
    input  logic [N_MST-1:0]              slv_pwrite_i,
    input  logic [N_MST*DATA_WIDTH-1:0]   slv_pwdata_i,
    output logic [N_MST-1:0]              slv_pready_o,
    output logic [N_MST*DATA_WIDTH-1:0]   slv_prdata_o,
    output logic [N_MST-1:0]              slv_pslverr_o,
    output logic [ADDR_WIDTH-1:0]         mst_paddr_o,
    output logic                          mst_pwrite_o,
    output logic [DATA_WIDTH-1:0]         mst_pwdata_o,
    output logic                          mst_psel_o,
    output logic                          mst_penable_o,
    input  logic                          mst_pready_i,
    input  logic [DATA_WIDTH-1:0]         mst_prdata_i,
    input  logic                          mst_pslverr_i,
    output logic                          busy_o,
    output logic [$clog2(N_MST)-1:0]      grant_idx_o
);

    localparam int IW = $clog2(N_MST);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e              state_r;
    logic [IW-1:0]           rr_ptr_r;
    logic [IW-1:0]           grant_idx_r;
    logic [CW-1:0]           to_cnt_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    pwrite_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    busy_r;

    logic [N_MST-1:0]        pick_oh_s;
    logic                    pick_valid_s;
    logic [MAX_MST-1:0]      pick_pad_s;
    logic [IW-1:0]           pick_idx_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic                    sel_write_s;
    logic                    timeout_s;
    logic                    done_s;
    logic [DATA_WIDTH-1:0]   rsp_data_s;
    logic                    rsp_err_s;

    apb_rr_pick #(
        .N_MST (N_MST)
    ) u_pick (
        .req       (slv_psel_i),
        .ptr       (rr_ptr_r),
        .gnt_oh    (pick_oh_s),
        .gnt_valid (pick_valid_s)
    );

    // Widen the one-hot pick for the shared decoder.
    always_comb begin
        pick_pad_s              = '0;
        pick_pad_s[N_MST-1:0]   = pick_oh_s;
    end

    assign pick_idx_s = IW'(onehot_to_bin(pick_pad_s));

    // Select the winning requester's transfer attributes for capture.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_write_s = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick_oh_s[i]) begin
                sel_addr_s  = slv_paddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_s = slv_pwdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write_s = slv_pwrite_i[i];
            end else begin
                sel_write_s = sel_write_s;
            end
        end
    end

    // A watchdog expiry completes upstream with an error even though the slave never answered.
    assign timeout_s  = WD_EN && (state_r == ACCESS) && (to_cnt_r == TO_LAST) && !mst_pready_i;
    assign done_s     = (state_r == ACCESS) && (mst_pready_i || timeout_s);
    assign rsp_data_s = timeout_s ? '0 : mst_prdata_i;
    assign rsp_err_s  = timeout_s ? 1'b1 : mst_pslverr_i;

    // Route the completion only to the granted requester; everyone else sees zeros.
    always_comb begin
        slv_pready_o  = '0;
        slv_prdata_o  = '0;
        slv_pslverr_o = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (done_s && (grant_idx_r == IW'(i))) begin
                slv_pready_o[i]                           = 1'b1;
                slv_prdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = rsp_data_s;
                slv_pslverr_o[i]                          = rsp_err_s;
            end else begin
                slv_pready_o[i] = 1'b0;
            end
        end
    end

    // Arbitration FSM with registered downstream phase control and captured attributes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            grant_idx_r <= '0;
            to_cnt_r    <= '0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            pwrite_r    <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_r     <= SETUP;
                        grant_idx_r <= pick_idx_s;
                        paddr_r     <= sel_addr_s;
                        pwdata_r    <= sel_wdata_s;
                        pwrite_r    <= sel_write_s;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    state_r   <= ACCESS;
                    penable_r <= 1'b1;
                    to_cnt_r  <= '0;
                end
                ACCESS: begin
                    if (done_s) begin
                        state_r   <= IDLE;
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        busy_r    <= 1'b0;
                        rr_ptr_r  <= IW'(rr_next(32'(grant_idx_r), 32'(N_MST)));
                    end else begin
                        to_cnt_r <= to_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign mst_paddr_o   = paddr_r;
    assign mst_pwdata_o  = pwdata_r;
    assign mst_pwrite_o  = pwrite_r;
    assign mst_psel_o    = psel_r;
    assign mst_penable_o = penable_r;
    assign busy_o        = busy_r;
    assign grant_idx_o   = grant_idx_r;

endmodule
